axi_tdd_ng_counter: RTL and testbench
=====================================

Name: axi_tdd_ng_counter

Overview:
Frame-timing engine of the TDD controller. It arms on enable, optionally waits for a sync event, and counts a startup delay. It then runs a free-running frame counter for a programmed number of frames. Its outputs (tdd_cstate, tdd_counter, tdd_endof_frame) drive every per-channel output stage in parallel.

Parameters:
REGISTER_WIDTH, 32, width of delay, frame length and counter.
BURST_COUNT_WIDTH, 32, width of the burst-count register and the internal frame tally.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
tdd_enable  in  1  global enable; low forces IDLE
tdd_sync_ext_en  in  1  1: wait in ARMED for a sync event; 0: leave ARMED immediately
tdd_sync  in  1  external sync, single-cycle pulse, already synchronised to clk
tdd_sync_soft  in  1  software sync, single-cycle pulse
tdd_startup_delay  in  REGISTER_WIDTH  cycles from trigger to first frame
tdd_frame_length  in  REGISTER_WIDTH  frame period in cycles
tdd_burst_count  in  BURST_COUNT_WIDTH  frames per burst; 0 = infinite
tdd_cstate  out  state_t  current state
tdd_counter  out  REGISTER_WIDTH  delay count in WAITING, in-frame position in RUNNING, 0 otherwise
tdd_endof_frame  out  1  high during the last cycle of each frame
tdd_endof_burst  out  1  high during the last cycle of the final frame of a finite burst

Behaviour:
- Reset (rst=1 at a clk edge): tdd_cstate=IDLE, tdd_counter=0, tdd_endof_frame=0, tdd_endof_burst=0, frame tally=0. Reset mid-run has the same effect on the next edge.
- All outputs are registered and mutually aligned. tdd_endof_frame=1 in the same cycle as tdd_counter==tdd_frame_length-1.
- Trigger = (tdd_sync | tdd_sync_soft) when tdd_sync_ext_en=1; constant 1 when tdd_sync_ext_en=0.
- IDLE -> ARMED when tdd_enable=1. Counter=0.
- ARMED, on trigger:
  - tdd_startup_delay==0: go to RUNNING with counter=0.
  - otherwise: go to WAITING with counter=0.
- WAITING: counter increments each cycle. When counter==tdd_startup_delay-1, the next cycle is RUNNING with counter=0.
- RUNNING: counter increments each cycle. At counter==tdd_frame_length-1: endof_frame=1, next counter=0, tally increments.
- Finite burst:
  - If tdd_burst_count!=0 and the tally reaches tdd_burst_count at a frame end, endof_burst=1 in that last cycle.
  - The next state is ARMED, with tally=0 and counter=0.
  - Re-running then waits for a new trigger.
- tdd_frame_length of 0 or 1 is treated as 1: counter stays 0 and endof_frame is high every RUNNING cycle.
- tdd_enable=0 in any state: the next state is IDLE, counter=0, flags=0, tally=0. This overrides all other events in the same cycle.
- Sync in WAITING or RUNNING is ignored (see Optional Feature).
- Sync in the same cycle as the ARMED entry is not seen; only ARMED-state cycles sample the trigger.
- Config inputs are quasi-static. They are sampled live; changing them while RUNNING is allowed but the effect is unspecified beyond no lock-up. Equality compares use ">=" so a shortened frame still wraps.
- Counter arithmetic is unsigned REGISTER_WIDTH and never wraps naturally, because the frame-end compare precedes it.

Optional Feature:
TDD_SYNC_RESTART_EN
- Defined: a trigger pulse (tdd_sync|tdd_sync_soft, with tdd_sync_ext_en=1) in WAITING or RUNNING restarts the sequence as if from ARMED. Next state is WAITING or RUNNING per the delay, counter=0, tally=0. No endof_frame or endof_burst is emitted for the truncated frame.
- Undefined: sync outside ARMED is ignored.

Decomposition:
- axi_tdd_ng_pkg (shared, existing) holds typedef state_t as 2-bit enum: IDLE=2'b00, ARMED=2'b01, WAITING=2'b10, RUNNING=2'b11. The channel stage consumes the same type.
- No sub-module: one FSM plus two counters, about 200 lines.

Test Plan:
- ext_en=0, delay=3, frame=5, burst=2, enable rises: ARMED 1 cycle, WAITING counter 0..2, RUNNING 0..4 twice. endof_frame at both counter=4 cycles, endof_burst on the second, then ARMED.
- ext_en=1, delay=0, frame=4, burst=0: holds ARMED indefinitely. tdd_sync pulse gives RUNNING next cycle with counter=0, then runs indefinitely, endof_burst never set.
- frame=1 and frame=0, burst=3: endof_frame high on 3 consecutive RUNNING cycles, endof_burst on the third, then ARMED.
- tdd_enable dropped at RUNNING counter=2, coincident with a frame end: next cycle IDLE, counter=0, both flags 0.
- rst pulsed in WAITING: next cycle IDLE and all outputs 0. After release with enable=1: ARMED.
- With TDD_SYNC_RESTART_EN, tdd_sync_soft at RUNNING counter=7 (frame=10, delay=2): WAITING counter=0, no endof_frame emitted. Without the macro: no effect, frame completes at 9.

Source files
------------

// File: rtl/axi_tdd_ng_pkg.sv
// Shared TDD controller types: the frame-timing state seen by the counter and
// every per-channel output stage.
package axi_tdd_ng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        WAITING = 2'b10,
        RUNNING = 2'b11
    } state_t;

endpackage

// File: rtl/axi_tdd_ng_counter.sv
// Frame-timing engine of the TDD controller: arm, optional sync, startup delay, burst of frames.
// Optional feature macro: TDD_SYNC_RESTART_EN (sync pulse restarts the sequence outside ARMED).
module axi_tdd_ng_counter
    import axi_tdd_ng_pkg::*;
#(
    parameter int REGISTER_WIDTH    = 32,
    parameter int BURST_COUNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tdd_enable,
    input  logic                         tdd_sync_ext_en,
    input  logic                         tdd_sync,
    input  logic                         tdd_sync_soft,
    input  logic [REGISTER_WIDTH-1:0]    tdd_startup_delay,
    input  logic [REGISTER_WIDTH-1:0]    tdd_frame_length,
    input  logic [BURST_COUNT_WIDTH-1:0] tdd_burst_count,
    output state_t                       tdd_cstate,
    output logic [REGISTER_WIDTH-1:0]    tdd_counter,
    output logic                         tdd_endof_frame,
    output logic                         tdd_endof_burst
);

    logic [BURST_COUNT_WIDTH-1:0] tally;

    logic                         trigger;
    logic                         restart;
    logic [REGISTER_WIDTH-1:0]    frame_last;
    logic [REGISTER_WIDTH-1:0]    counter_inc;
    logic                         delay_done;
    logic                         frame_done_next;
    logic                         burst_done_next;
    logic                         burst_done_wrap;
    logic                         first_eof;
    logic                         first_eob;
    state_t                       start_state;
    logic                         start_eof;
    logic                         start_eob;

    // Flags are registered, so each one is computed for the cycle being entered.
    always_comb begin
        trigger     = tdd_sync_ext_en ? (tdd_sync | tdd_sync_soft) : 1'b1;
        frame_last  = (tdd_frame_length <= REGISTER_WIDTH'(1)) ? '0
                    : tdd_frame_length - REGISTER_WIDTH'(1);
        counter_inc = tdd_counter + REGISTER_WIDTH'(1);
        delay_done  = ({1'b0, tdd_counter} + (REGISTER_WIDTH+1)'(1)) >= {1'b0, tdd_startup_delay};

        frame_done_next = counter_inc >= frame_last;
        burst_done_next = (tdd_burst_count != '0)
                        && (({1'b0, tally} + (BURST_COUNT_WIDTH+1)'(1)) >= {1'b0, tdd_burst_count});
        burst_done_wrap = (tdd_burst_count != '0)
                        && (({1'b0, tally} + (BURST_COUNT_WIDTH+1)'(2)) >= {1'b0, tdd_burst_count});

        first_eof = (frame_last == '0);
        first_eob = first_eof && (tdd_burst_count == BURST_COUNT_WIDTH'(1));

        start_state = (tdd_startup_delay == '0) ? RUNNING : WAITING;
        start_eof   = (tdd_startup_delay == '0) && first_eof;
        start_eob   = (tdd_startup_delay == '0) && first_eob;
    end

`ifdef TDD_SYNC_RESTART_EN
    assign restart = tdd_sync_ext_en & (tdd_sync | tdd_sync_soft);
`else
    assign restart = 1'b0;
`endif

    // Disable has priority over every other event; a restart outranks frame completion.
    always_ff @(posedge clk) begin
        if (rst || !tdd_enable) begin
            tdd_cstate      <= IDLE;
            tdd_counter     <= '0;
            tdd_endof_frame <= 1'b0;
            tdd_endof_burst <= 1'b0;
            tally           <= '0;
        end else begin
            case (tdd_cstate)
                IDLE: begin
                    tdd_cstate      <= ARMED;
                    tdd_counter     <= '0;
                    tdd_endof_frame <= 1'b0;
                    tdd_endof_burst <= 1'b0;
                    tally           <= '0;
                end
                ARMED: begin
                    tdd_counter <= '0;
                    tally       <= '0;
                    if (trigger) begin
                        tdd_cstate      <= start_state;
                        tdd_endof_frame <= start_eof;
                        tdd_endof_burst <= start_eob;
                    end else begin
                        tdd_endof_frame <= 1'b0;
                        tdd_endof_burst <= 1'b0;
                    end
                end
                WAITING: begin
                    tally <= '0;
                    if (restart) begin
                        tdd_cstate      <= start_state;
                        tdd_counter     <= '0;
                        tdd_endof_frame <= start_eof;
                        tdd_endof_burst <= start_eob;
                    end else if (delay_done) begin
                        tdd_cstate      <= RUNNING;
                        tdd_counter     <= '0;
                        tdd_endof_frame <= first_eof;
                        tdd_endof_burst <= first_eob;
                    end else begin
                        tdd_counter     <= counter_inc;
                        tdd_endof_frame <= 1'b0;
                        tdd_endof_burst <= 1'b0;
                    end
                end
                RUNNING: begin
                    if (restart) begin
                        tdd_cstate      <= start_state;
                        tdd_counter     <= '0;
                        tdd_endof_frame <= start_eof;
                        tdd_endof_burst <= start_eob;
                        tally           <= '0;
                    end else if (tdd_endof_frame && tdd_endof_burst) begin
                        tdd_cstate      <= ARMED;
                        tdd_counter     <= '0;
                        tdd_endof_frame <= 1'b0;
                        tdd_endof_burst <= 1'b0;
                        tally           <= '0;
                    end else if (tdd_endof_frame || tdd_counter >= frame_last) begin
                        tdd_counter     <= '0;
                        tdd_endof_frame <= first_eof;
                        tdd_endof_burst <= first_eof && burst_done_wrap;
                        tally           <= tally + BURST_COUNT_WIDTH'(1);
                    end else begin
                        tdd_counter     <= counter_inc;
                        tdd_endof_frame <= frame_done_next;
                        tdd_endof_burst <= frame_done_next && burst_done_next;
                    end
                end
                default: begin
                    tdd_cstate      <= IDLE;
                    tdd_counter     <= '0;
                    tdd_endof_frame <= 1'b0;
                    tdd_endof_burst <= 1'b0;
                    tally           <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_tdd_ng_counter.sv
// Directed self-checking bench for axi_tdd_ng_counter; honours TDD_SYNC_RESTART_EN if defined.
module tb_axi_tdd_ng_counter;
    import axi_tdd_ng_pkg::*;

    logic        clk;
    logic        rst;
    logic        tdd_enable;
    logic        tdd_sync_ext_en;
    logic        tdd_sync;
    logic        tdd_sync_soft;
    logic [31:0] tdd_startup_delay;
    logic [31:0] tdd_frame_length;
    logic [31:0] tdd_burst_count;
    state_t      tdd_cstate;
    logic [31:0] tdd_counter;
    logic        tdd_endof_frame;
    logic        tdd_endof_burst;

    int checks = 0;
    int errors = 0;

    axi_tdd_ng_counter #(
        .REGISTER_WIDTH    (32),
        .BURST_COUNT_WIDTH (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .tdd_enable        (tdd_enable),
        .tdd_sync_ext_en   (tdd_sync_ext_en),
        .tdd_sync          (tdd_sync),
        .tdd_sync_soft     (tdd_sync_soft),
        .tdd_startup_delay (tdd_startup_delay),
        .tdd_frame_length  (tdd_frame_length),
        .tdd_burst_count   (tdd_burst_count),
        .tdd_cstate        (tdd_cstate),
        .tdd_counter       (tdd_counter),
        .tdd_endof_frame   (tdd_endof_frame),
        .tdd_endof_burst   (tdd_endof_burst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then settle on the falling edge where inputs change and outputs are sampled.
    task automatic applyStimulus();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input state_t exp_state, input int exp_counter,
                               input logic exp_eof, input logic exp_eob);
        checks++;
        assert (tdd_cstate === exp_state) else begin
            errors++;
            $error("[TB] FAIL %s state got %0d expected %0d", tag, tdd_cstate, exp_state);
        end
        checks++;
        assert (tdd_counter === 32'(exp_counter)) else begin
            errors++;
            $error("[TB] FAIL %s counter got %0d expected %0d", tag, tdd_counter, exp_counter);
        end
        checks++;
        assert (tdd_endof_frame === exp_eof) else begin
            errors++;
            $error("[TB] FAIL %s endof_frame got %b expected %b", tag, tdd_endof_frame, exp_eof);
        end
        checks++;
        assert (tdd_endof_burst === exp_eob) else begin
            errors++;
            $error("[TB] FAIL %s endof_burst got %b expected %b", tag, tdd_endof_burst, exp_eob);
        end
    endtask

    initial begin
        rst               = 1'b1;
        tdd_enable        = 1'b0;
        tdd_sync_ext_en   = 1'b0;
        tdd_sync          = 1'b0;
        tdd_sync_soft     = 1'b0;
        tdd_startup_delay = 32'd3;
        tdd_frame_length  = 32'd5;
        tdd_burst_count   = 32'd2;
        @(negedge clk);
        applyStimulus();
        checkOutput("reset", IDLE, 0, 1'b0, 1'b0);

        // Free-running trigger: delay 3, two frames of 5, then back to ARMED.
        rst        = 1'b0;
        tdd_enable = 1'b1;
        applyStimulus();
        checkOutput("t1_armed", ARMED, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("t1_wait", WAITING, i, 1'b0, 1'b0);
        end
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 5; i++) begin
                applyStimulus();
                checkOutput("t1_run", RUNNING, i, i == 4, (f == 1) && (i == 4));
            end
        end
        applyStimulus();
        checkOutput("t1_rearm", ARMED, 0, 1'b0, 1'b0);
        tdd_enable = 1'b0;
        applyStimulus();
        checkOutput("t1_idle", IDLE, 0, 1'b0, 1'b0);

        // External sync, no delay, infinite burst.
        tdd_sync_ext_en   = 1'b1;
        tdd_startup_delay = 32'd0;
        tdd_frame_length  = 32'd4;
        tdd_burst_count   = 32'd0;
        tdd_enable        = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkOutput("t2_armed", ARMED, 0, 1'b0, 1'b0);
        end
        tdd_sync = 1'b1;
        applyStimulus();
        tdd_sync = 1'b0;
        checkOutput("t2_start", RUNNING, 0, 1'b0, 1'b0);
        for (int n = 1; n < 12; n++) begin
            applyStimulus();
            checkOutput("t2_run", RUNNING, n % 4, (n % 4) == 3, 1'b0);
        end
        tdd_enable = 1'b0;
        applyStimulus();
        checkOutput("t2_idle", IDLE, 0, 1'b0, 1'b0);

        // Single-cycle frames (length 1, then 0), burst of 3.
        tdd_sync_ext_en  = 1'b0;
        tdd_frame_length = 32'd1;
        tdd_burst_count  = 32'd3;
        tdd_enable       = 1'b1;
        applyStimulus();
        checkOutput("t3_armed", ARMED, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("t3_len1", RUNNING, 0, 1'b1, i == 2);
        end
        tdd_frame_length = 32'd0;
        applyStimulus();
        checkOutput("t3_rearm", ARMED, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("t3_len0", RUNNING, 0, 1'b1, i == 2);
        end
        applyStimulus();
        checkOutput("t3_rearm0", ARMED, 0, 1'b0, 1'b0);

        // Disable coincident with a frame end at counter 2.
        tdd_enable = 1'b0;
        applyStimulus();
        checkOutput("t4_idle0", IDLE, 0, 1'b0, 1'b0);
        tdd_frame_length = 32'd3;
        tdd_burst_count  = 32'd0;
        tdd_enable       = 1'b1;
        applyStimulus();
        checkOutput("t4_armed", ARMED, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("t4_run", RUNNING, i, i == 2, 1'b0);
        end
        tdd_enable = 1'b0;
        applyStimulus();
        checkOutput("t4_drop", IDLE, 0, 1'b0, 1'b0);

        // Reset while WAITING.
        tdd_startup_delay = 32'd4;
        tdd_frame_length  = 32'd5;
        tdd_enable        = 1'b1;
        applyStimulus();
        checkOutput("t5_armed", ARMED, 0, 1'b0, 1'b0);
        applyStimulus();
        checkOutput("t5_wait0", WAITING, 0, 1'b0, 1'b0);
        applyStimulus();
        checkOutput("t5_wait1", WAITING, 1, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus();
        checkOutput("t5_reset", IDLE, 0, 1'b0, 1'b0);
        rst             = 1'b0;
        tdd_sync_ext_en = 1'b1;
        applyStimulus();
        checkOutput("t5_rearm", ARMED, 0, 1'b0, 1'b0);

        // Soft sync at RUNNING counter 7 of a 10-cycle frame, delay 2.
        tdd_startup_delay = 32'd2;
        tdd_frame_length  = 32'd10;
        tdd_burst_count   = 32'd0;
        tdd_sync_soft     = 1'b1;
        applyStimulus();
        tdd_sync_soft = 1'b0;
        checkOutput("t6_wait0", WAITING, 0, 1'b0, 1'b0);
        applyStimulus();
        checkOutput("t6_wait1", WAITING, 1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus();
            checkOutput("t6_run", RUNNING, i, 1'b0, 1'b0);
        end
        tdd_sync_soft = 1'b1;
        applyStimulus();
        tdd_sync_soft = 1'b0;
`ifdef TDD_SYNC_RESTART_EN
        checkOutput("t6_restart", WAITING, 0, 1'b0, 1'b0);
        applyStimulus();
        checkOutput("t6_rwait1", WAITING, 1, 1'b0, 1'b0);
        applyStimulus();
        checkOutput("t6_rrun0", RUNNING, 0, 1'b0, 1'b0);
`else
        checkOutput("t6_ignored", RUNNING, 8, 1'b0, 1'b0);
        applyStimulus();
        checkOutput("t6_end", RUNNING, 9, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("t6_wrap", RUNNING, 0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
